// File: rtl/ov7670_stream_source.sv
// rtl/ov7670_stream_source.sv - OV7670-style vsync/href/data byte stream generator with test patterns
// All outputs are registered from the next-cycle position (state_d/col_d/line_d).
module ov7670_stream_source #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 288,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        cam_href,
  output logic        cam_vsync,
  output logic [7:0]  cam_data,
  output logic        frame_start,
  output logic        busy
);

  localparam int L       = 2*H_ACTIVE + H_BLANK;
  localparam int COL_W   = $clog2(L);
  localparam int LINE_W  = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);
  localparam int BAR_PIX = H_ACTIVE / 8;
  localparam int BAR_W   = $clog2(BAR_PIX + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(L - 1);
  localparam logic [COL_W-1:0] HREF_END = COL_W'(2*H_ACTIVE);
  localparam logic [BAR_W-1:0] BAR_LAST = BAR_W'(BAR_PIX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT
  } state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [BAR_W-1:0]  bar_pix_q, bar_pix_d;
  logic [2:0]        bar_idx_q, bar_idx_d;
  logic [1:0]        sel_q, sel_d;
  logic [15:0]       rgb_q, rgb_d;
  logic              href_q, href_d;
  logic              vsync_q, vsync_d;
  logic [7:0]        data_q, data_d;
  logic              fs_q, fs_d;
  logic              busy_q, busy_d;

  logic [LINE_W-1:0] line_last;
  logic [15:0]       pix;
  logic [15:0]       bar_rgb;
  logic [5:0]        ramp_x;
  logic              chk;

  always_comb begin
    line_last = '0;
    case (state_q)
      S_VSYNC:  line_last = LINE_W'(VSYNC_LINES - 1);
      S_VBACK:  line_last = LINE_W'(V_BACK - 1);
      S_ACTIVE: line_last = LINE_W'(V_ACTIVE - 1);
      S_VFRONT: line_last = LINE_W'(V_FRONT - 1);
      default:  line_last = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    sel_d   = sel_q;
    rgb_d   = rgb_q;
    fs_d    = 1'b0;
    if (state_q == S_IDLE) begin
      if (enable) begin
        state_d = S_VSYNC;
        col_d   = '0;
        line_d  = '0;
        sel_d   = pattern_sel;
        rgb_d   = solid_rgb;
        fs_d    = 1'b1;
      end
    end else if (col_q == COL_LAST) begin
      col_d = '0;
      if (line_q == line_last) begin
        line_d = '0;
        case (state_q)
          S_VSYNC:  state_d = S_VBACK;
          S_VBACK:  state_d = S_ACTIVE;
          S_ACTIVE: state_d = S_VFRONT;
          default: begin
            // Back-to-back frames: restart without passing through IDLE
            if (enable) begin
              state_d = S_VSYNC;
              sel_d   = pattern_sel;
              rgb_d   = solid_rgb;
              fs_d    = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        endcase
      end else begin
        line_d = line_q + 1'b1;
      end
    end else begin
      col_d = col_q + 1'b1;
    end
  end

  // Bar position advances on each new pixel instead of dividing x
  always_comb begin
    bar_pix_d = bar_pix_q;
    bar_idx_d = bar_idx_q;
    if (col_d == '0) begin
      bar_pix_d = '0;
      bar_idx_d = '0;
    end else if (col_q[0]) begin
      if (bar_pix_q == BAR_LAST) begin
        bar_pix_d = '0;
        bar_idx_d = bar_idx_q + 1'b1;
      end else begin
        bar_pix_d = bar_pix_q + 1'b1;
      end
    end
  end

  always_comb begin
    bar_rgb = 16'h0000;
    case (bar_idx_d)
      3'd0: bar_rgb = 16'hFFFF;
      3'd1: bar_rgb = 16'hFFE0;
      3'd2: bar_rgb = 16'h07FF;
      3'd3: bar_rgb = 16'h07E0;
      3'd4: bar_rgb = 16'hF81F;
      3'd5: bar_rgb = 16'hF800;
      3'd6: bar_rgb = 16'h001F;
      default: bar_rgb = 16'h0000;
    endcase
  end

  always_comb begin
    ramp_x = 6'(32'(col_d) >> 3);
    chk    = 1'((32'(col_d) >> 4) ^ (32'(line_d) >> 3));
    pix    = 16'h0000;
    case (sel_d)
      2'd0: pix = bar_rgb;
      2'd1: pix = rgb_d;
      2'd2: pix = {ramp_x[5:1], ramp_x, ramp_x[5:1]};
      default: pix = chk ? 16'hFFFF : 16'h0000;
    endcase
  end

  always_comb begin
    vsync_d = (state_d == S_VSYNC);
    busy_d  = (state_d != S_IDLE);
    href_d  = (state_d == S_ACTIVE) && (col_d < HREF_END);
    data_d  = 8'h00;
    if (href_d) begin
      data_d = col_d[0] ? pix[7:0] : pix[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      line_q    <= '0;
      bar_pix_q <= '0;
      bar_idx_q <= '0;
      sel_q     <= '0;
      rgb_q     <= '0;
      href_q    <= 1'b0;
      vsync_q   <= 1'b0;
      data_q    <= 8'h00;
      fs_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      line_q    <= line_d;
      bar_pix_q <= bar_pix_d;
      bar_idx_q <= bar_idx_d;
      sel_q     <= sel_d;
      rgb_q     <= rgb_d;
      href_q    <= href_d;
      vsync_q   <= vsync_d;
      data_q    <= data_d;
      fs_q      <= fs_d;
      busy_q    <= busy_d;
    end
  end

  assign cam_href    = href_q;
  assign cam_vsync   = vsync_q;
  assign cam_data    = data_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ov7670_stream_source.sv
// tb/tb_ov7670_stream_source.sv - scoreboard bench for ov7670_stream_source
module tb_ov7670_stream_source;

  localparam int HA = 16, HB = 8, VS = 1, VB = 1, VA = 4, VF = 1;
  localparam int LL = 2*HA + HB;
  localparam int FRAME = (VS + VB + VA + VF) * LL;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_rgb = 16'h0000;
  logic        cam_href, cam_vsync, frame_start, busy;
  logic [7:0]  cam_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  ov7670_stream_source #(
    .H_ACTIVE(HA), .H_BLANK(HB), .VSYNC_LINES(VS),
    .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .cam_href(cam_href), .cam_vsync(cam_vsync), .cam_data(cam_data),
    .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got vs/href/fs/busy/data=%03h expected=%03h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: frame position as a flat cycle offset
  logic [15:0] bars [8];
  initial bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  bit          m_run = 0;
  int          m_pos = 0;
  bit          m_fs = 0;
  logic [1:0]  m_sel = 0;
  logic [15:0] m_rgb = 0;
  logic [11:0] sb_q [$];

  function automatic logic [15:0] model_pix(input int x, input int y);
    logic [7:0] g;
    case (m_sel)
      2'd0: return bars[x / (HA/8)];
      2'd1: return m_rgb;
      2'd2: begin
        g = 8'(x % 256);
        return {g[7:3], g[7:2], g[7:3]};
      end
      default: return (((x / 8) % 2) != ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  function automatic logic [11:0] model_out();
    int line, col;
    bit vs, hr;
    logic [15:0] p;
    logic [7:0] d;
    if (!m_run) return 12'h000;
    line = m_pos / LL;
    col  = m_pos % LL;
    vs = (line < VS);
    hr = (line >= VS + VB) && (line < VS + VB + VA) && (col < 2*HA);
    d = 8'h00;
    if (hr) begin
      p = model_pix(col / 2, line - VS - VB);
      d = (col % 2 == 0) ? p[15:8] : p[7:0];
    end
    return {vs, hr, m_fs, 1'b1, d};
  endfunction

  always @(posedge clk) begin
    m_fs = 0;
    if (reset) begin
      m_run = 0;
      m_pos = 0;
    end else if (!m_run) begin
      if (enable) begin
        m_run = 1; m_pos = 0; m_fs = 1;
        m_sel = pattern_sel; m_rgb = solid_rgb;
      end
    end else if (m_pos == FRAME - 1) begin
      if (enable) begin
        m_pos = 0; m_fs = 1;
        m_sel = pattern_sel; m_rgb = solid_rgb;
      end else begin
        m_run = 0; m_pos = 0;
      end
    end else begin
      m_pos++;
    end
    sb_q.push_back(model_out());
  end

  always @(negedge clk) begin
    cyc++;
    if (sb_q.size() > 0)
      check_eq("outputs", {cam_vsync, cam_href, frame_start, busy, cam_data}, sb_q.pop_front());
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    run(3);
    reset = 1'b0;
    run(5);
    // colour bars, continuous frames
    enable = 1'b1; pattern_sel = 2'd0;
    run(2*FRAME + 30);
    // solid for the next frame, then checker requested mid-frame
    pattern_sel = 2'd1; solid_rgb = 16'hF81F;
    run(FRAME);
    pattern_sel = 2'd3; solid_rgb = 16'h1234;
    run(FRAME);
    // grey ramp
    pattern_sel = 2'd2;
    run(FRAME + 20);
    // wait for active line 1 column 10 of a fresh frame, then drop enable
    @(negedge clk);
    while (!frame_start && cyc < 20000) @(negedge clk);
    run(3*LL + 10);
    enable = 1'b0;
    run(2*FRAME);
    // restart and reset mid-active-line
    enable = 1'b1; pattern_sel = 2'd0;
    run(2*LL + 12);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(FRAME + 50);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
